// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_pkg
//  Purpose  : Shared AXI4-Lite response codes, address layout and the
//             byte-strobe merge helper used by register-file slaves.
//  Revision : 1.0  initial release
// ============================================================================
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // Registers are 32-bit words, so the byte offset within a word is dropped.
  localparam int ADDR_LSB = 2;

  // Replace only the bytes whose strobe bit is set; keep the rest of old_word.
  function automatic logic [31:0] wstrb_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_regfile_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_regfile_slave
//  Purpose  : AXI4-Lite slave holding NUM_REGS read/write 32-bit registers
//             with byte-strobe writes, SLVERR on out-of-range accesses, and
//             flattened register contents plus per-register write pulses.
//  Revision : 1.0  initial release
// ============================================================================
module axi_lite_regfile_slave
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 8
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESET,
  input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                reg_wr_pulse
);

  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // Write-side holding state: address and data are captured independently.
  logic                      r_aw_full;
  logic                      r_w_full;
  logic [IDX_W-1:0]          r_aw_idx;
  logic [AXI_DATA_WIDTH-1:0] r_w_data;
  logic [STRB_W-1:0]         r_w_strb;

  logic                      r_bvalid;
  resp_t                     r_bresp;
  logic                      r_rvalid;
  resp_t                     r_rresp;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [NUM_REGS-1:0]       r_wr_pulse;

  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_ar_hs;
  logic                      w_commit;
  logic                      w_aw_in_range;
  logic                      w_ar_in_range;
  logic [IDX_W-1:0]          w_ar_idx;
  logic [AXI_DATA_WIDTH-1:0] w_ar_word;
  logic [NUM_REGS-1:0]       w_reg_we;
  logic                      w_unused_ok;

  // Readies come from registered state only and are held low in reset.
  assign S_AXI_AWREADY = ~S_AXI_ARESET & ~r_aw_full & ~r_bvalid;
  assign S_AXI_WREADY  = ~S_AXI_ARESET & ~r_w_full  & ~r_bvalid;
  assign S_AXI_ARREADY = ~S_AXI_ARESET & ~r_rvalid;

  assign w_aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_w_hs   = S_AXI_WVALID  & S_AXI_WREADY;
  assign w_ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign w_commit = r_aw_full & r_w_full & ~r_bvalid;

  assign w_ar_idx      = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
  assign w_aw_in_range = ({1'b0, r_aw_idx} < (IDX_W+1)'(NUM_REGS));
  assign w_ar_in_range = ({1'b0, w_ar_idx} < (IDX_W+1)'(NUM_REGS));

  // Protection bits and address bits outside the index field carry no meaning here.
  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, RESP_DECERR};

  // Read-data mux and per-register write enables; an unmatched index yields 0 / no enable.
  always_comb begin
    w_ar_word = '0;
    w_reg_we  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == IDX_W'(i)) w_ar_word = r_regs[i];
      if (w_commit && (r_aw_idx == IDX_W'(i))) w_reg_we[i] = 1'b1;
    end
  end

  // Capture AW and W into their holding slots; a commit empties both.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_aw_idx  <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= S_AXI_AWADDR[ADDR_LSB +: IDX_W];
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= S_AXI_WDATA;
        r_w_strb <= S_AXI_WSTRB;
      end
    end
  end

  // Register storage: byte-merged update of the addressed register at commit.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_reg_we[i]) r_regs[i] <= wstrb_merge(r_regs[i], r_w_data, r_w_strb);
      end
    end
  end

  // Write response and the one-cycle write pulse that follows a successful commit.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_reg_we;
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read response: sampled at the AR handshake and held until RREADY.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ar_in_range ? w_ar_word : '0;
      r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
      assign reg_out[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = r_regs[gi];
    end
  endgenerate

  assign S_AXI_BVALID = r_bvalid;
  assign S_AXI_BRESP  = r_bresp;
  assign S_AXI_RVALID = r_rvalid;
  assign S_AXI_RDATA  = r_rdata;
  assign S_AXI_RRESP  = r_rresp;
  assign reg_wr_pulse = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_regfile_slave
//  Purpose  : Self-checking bench for axi_lite_regfile_slave (8-register and
//             6-register instances driven from the same bus stimulus).
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_lite_regfile_slave;

  logic        clk;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [255:0] reg_out;
  logic [7:0]  pulse;

  logic        awready6, wready6, bvalid6, arready6, rvalid6;
  logic [1:0]  bresp6, rresp6;
  logic [31:0] rdata6;
  logic [191:0] reg_out6;
  logic [5:0]  pulse6;

  int total = 0;
  int bad   = 0;

  logic [33:0] sb [$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [13];

  axi_lite_regfile_slave #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(pulse)
  );

  axi_lite_regfile_slave #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .NUM_REGS(6)) dut6 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready6),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready6),
    .S_AXI_BRESP(bresp6), .S_AXI_BVALID(bvalid6), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready6),
    .S_AXI_RDATA(rdata6), .S_AXI_RRESP(rresp6), .S_AXI_RVALID(rvalid6), .S_AXI_RREADY(rready),
    .reg_out(reg_out6), .reg_wr_pulse(pulse6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: every completed R beat is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rvalid && rready) begin
      if (sb.size() == 0) begin
        chk("r_unexpected", 64'd1, 64'd0);
      end else begin
        logic [33:0] e;
        e = sb.pop_front();
        chk("rdata", {32'd0, rdata}, {32'd0, e[33:2]});
        chk("rresp", {62'd0, rresp}, {62'd0, e[1:0]});
      end
    end
  end

  // Present AW and W together at a negedge; returns just after the handshake edge.
  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aw_w_accept_timeout", {63'd0, n >= 20}, 64'd0);
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  // Called just after the last write handshake edge; returns at the negedge showing BVALID.
  task automatic wait_b(input logic [1:0] er, input int idx, input logic [31:0] eword);
    int cyc;
    cyc = 0;
    while (!bvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("b_latency", cyc, 2);
    chk("bresp", {62'd0, bresp}, {62'd0, er});
    chk("wr_pulse", {56'd0, pulse}, {56'd0, 8'(1 << idx)});
    chk("reg_word", {32'd0, reg_out[idx*32 +: 32]}, {32'd0, eword});
  endtask

  task automatic ack_b();
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    @(negedge clk);
    chk("bvalid_clear", {63'd0, bvalid}, 64'd0);
    chk("pulse_clear", {56'd0, pulse}, 64'd0);
  endtask

  // Issue an AR, queue its expected response, and check the one-cycle latency.
  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    int n;
    n = 0;
    sb.push_back({ed, er});
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept_timeout", {63'd0, n >= 20}, 64'd0);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("r_latency", {63'd0, rvalid}, 64'd1);
  endtask

  initial begin
    logic [191:0] snap6;

    tbl[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h08, 32'h12345678, 4'h3, 32'hDEAD5678};
    tbl[3]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDEAD5678};
    tbl[4]  = '{1'b1, 32'h00, 32'h11223344, 4'hF, 32'h11223344};
    tbl[5]  = '{1'b1, 32'h00, 32'hAABBCCDD, 4'hA, 32'hAA22CC44};
    tbl[6]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'hAA22CC44};
    tbl[7]  = '{1'b1, 32'h1C, 32'h0F0F0F0F, 4'hF, 32'h0F0F0F0F};
    tbl[8]  = '{1'b0, 32'h1C, 32'h0,        4'h0, 32'h0F0F0F0F};
    tbl[9]  = '{1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 32'h00000000};
    tbl[10] = '{1'b0, 32'h14, 32'h0,        4'h0, 32'h00000000};
    tbl[11] = '{1'b0, 32'h2A, 32'h0,        4'h0, 32'hDEAD5678};
    tbl[12] = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h00000000};

    rst = 1'b1;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b0; rready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_awready", {63'd0, awready}, 64'd0);
    chk("rst_wready",  {63'd0, wready},  64'd0);
    chk("rst_arready", {63'd0, arready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {61'd0, awready, wready, arready}, 64'd7);
    chk("rst_valids", {62'd0, bvalid, rvalid}, 64'd0);
    chk("rst_reg_out_lo", reg_out[63:0], 64'd0);
    chk("rst_reg_out_hi", reg_out[255:192], 64'd0);
    chk("rst_pulse", {56'd0, pulse}, 64'd0);
    chk("rst_rdata", {30'd0, rdata, rresp}, 64'd0);
    chk("rst_bresp", {62'd0, bresp}, 64'd0);

    // Table-driven writes and reads on the 8-register instance
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) begin
        int idx;
        idx = int'(tbl[i].addr[4:2]);
        send_aw_w(tbl[i].addr, tbl[i].data, tbl[i].strb);
        wait_b(2'b00, idx, tbl[i].exp);
        ack_b();
      end else begin
        do_read(tbl[i].addr, tbl[i].exp, 2'b00);
      end
    end

    // W arrives three cycles ahead of AW
    @(negedge clk);
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    chk("early_w_ready", {63'd0, wready}, 64'd1);
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("early_w_wready_low", {63'd0, wready}, 64'd0);
      chk("early_w_no_commit", {63'd0, bvalid}, 64'd0);
    end
    awaddr = 32'h04; awvalid = 1'b1;
    chk("late_aw_ready", {63'd0, awready}, 64'd1);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wait_b(2'b00, 1, 32'hA5A5A5A5);
    ack_b();
    repeat (3) begin
      @(negedge clk);
      chk("single_commit", {63'd0, bvalid}, 64'd0);
    end
    do_read(32'h04, 32'hA5A5A5A5, 2'b00);

    // Out-of-range on the 6-register instance (index 6 / 7); in range on the 8-register one
    snap6 = reg_out6;
    send_aw_w(32'h18, 32'hFFFFFFFF, 4'hF);
    wait_b(2'b00, 6, 32'hFFFFFFFF);
    chk("oor_bvalid6", {63'd0, bvalid6}, 64'd1);
    chk("oor_bresp6", {62'd0, bresp6}, {62'd0, 2'b10});
    chk("oor_pulse6", {58'd0, pulse6}, 64'd0);
    ack_b();
    total++;
    if (reg_out6 !== snap6) begin
      bad++;
      $display("FAIL oor_regs6: got %h expected %h", reg_out6, snap6);
    end
    do_read(32'h1C, 32'h0F0F0F0F, 2'b00);
    chk("oor_rvalid6", {63'd0, rvalid6}, 64'd1);
    chk("oor_rdata6", {32'd0, rdata6}, 64'd0);
    chk("oor_rresp6", {62'd0, rresp6}, {62'd0, 2'b10});
    do_read(32'h18, 32'hFFFFFFFF, 2'b00);

    // BREADY stalled for 5 cycles with a second write waiting
    send_aw_w(32'h0C, 32'h55AA55AA, 4'hF);
    wait_b(2'b00, 3, 32'h55AA55AA);
    awaddr = 32'h10; wdata = 32'h00000077; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_bvalid", {63'd0, bvalid}, 64'd1);
      chk("stall_bresp", {62'd0, bresp}, 64'd0);
      chk("stall_readies", {62'd0, awready, wready}, 64'd0);
      if (k > 0) chk("stall_pulse_once", {56'd0, pulse}, 64'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    @(negedge clk);
    chk("stall_released_bvalid", {63'd0, bvalid}, 64'd0);
    chk("second_not_yet_taken", {62'd0, awready, wready}, 64'd3);
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b(2'b00, 4, 32'h00000077);
    ack_b();

    // Reset while both B and R responses are pending
    rready = 1'b0;
    send_aw_w(32'h10, 32'h99999999, 4'hF);
    @(negedge clk);
    araddr = 32'h08; arvalid = 1'b1;
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valids", {62'd0, bvalid, rvalid}, 64'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valids", {62'd0, bvalid, rvalid}, 64'd0);
    total++;
    if (reg_out !== 256'd0) begin
      bad++;
      $display("FAIL mid_rst_reg_out: got %h expected 0", reg_out);
    end
    rst = 1'b0;
    rready = 1'b1;
    send_aw_w(32'h00, 32'hCAFEF00D, 4'hF);
    wait_b(2'b00, 0, 32'hCAFEF00D);
    ack_b();
    do_read(32'h00, 32'hCAFEF00D, 2'b00);
    do_read(32'h08, 32'h00000000, 2'b00);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_regfile_slave.md
Name: axi_lite_regfile_slave

Overview:
- AXI4-Lite slave register file; sits directly downstream of axi_lite_master and accepts its AW/W/B/AR/R transactions.
- Holds NUM_REGS software-visible 32-bit registers, all read/write, with byte-strobe merge on writes.
- Exports the register contents and per-register write strobes to downstream logic (Lenia control/config).
- Out-of-range accesses complete with SLVERR. No access ever hangs the bus.

Parameters:
- AXI_ADDR_WIDTH, 32, address width of the AW/AR channels.
- AXI_DATA_WIDTH, 32, data width. Only 32 is supported.
- NUM_REGS, 8, number of registers, from 1 to 64. Does not have to be a power of 2.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESET  in  1  reset. One clock; reset is synchronous and active-high.
- S_AXI_AWADDR  in  AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  write protection; ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  AXI_DATA_WIDTH  write data
- S_AXI_WSTRB  in  AXI_DATA_WIDTH/8  byte enables
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  read protection; ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  AXI_DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- reg_out  out  NUM_REGS*AXI_DATA_WIDTH  flattened register contents; register i occupies bits [32i+31:32i]
- reg_wr_pulse  out  NUM_REGS  one-cycle strobe per register on a successful write

Behaviour:
- Reset values:
  - All registers, reg_out and reg_wr_pulse are 0.
  - BVALID and RVALID are 0.
  - BRESP, RRESP and RDATA are 0.
  - aw_full and w_full are 0.
  - All READY outputs are forced 0 while S_AXI_ARESET=1.
- Address decode:
  - idx = addr[2 +: IDX_W], where IDX_W = max(1, clog2(NUM_REGS)).
  - Bits [1:0] and bits above the index field are ignored; the interconnect decodes the base address.
  - idx >= NUM_REGS is out of range.
- Write path:
  - AW and W are accepted independently, in either order, into holding registers tracked by aw_full and w_full.
  - AWREADY = ~aw_full & ~BVALID; WREADY = ~w_full & ~BVALID. Both are combinational from registered state.
  - Commit happens at the edge where aw_full & w_full & ~BVALID.
  - In range: each byte b is written only where WSTRB[b]=1. BRESP=OKAY (00), and reg_wr_pulse[idx]=1 for exactly the following cycle.
  - Out of range: no register changes and no pulse. BRESP=SLVERR (10).
  - At commit: BVALID←1, and aw_full and w_full are cleared.
  - BVALID holds, with BRESP stable, until BREADY=1. It clears at that edge.
  - Latency: BVALID rises on the first edge after the edge on which the later of AW/W handshakes.
  - Only one write is outstanding at a time.
- Read path:
  - ARREADY = ~RVALID.
  - On the AR handshake edge, RVALID←1, RDATA←reg[idx] and RRESP=OKAY.
  - Out of range: RDATA=0 and RRESP=SLVERR.
  - RVALID, RDATA and RRESP hold until RREADY=1. RVALID clears at that edge.
  - Latency: 1 cycle. Back-to-back reads complete every 2 cycles.
- Simultaneous events:
  - Read handshake on the same edge as a write commit to the same register returns the pre-write value.
  - Read and write channels are fully independent.
- Reset mid-operation:
  - Pending AW/W holding data and any pending B/R response are discarded at the reset edge.
  - BVALID and RVALID are 0 on the first edge with reset asserted.
- AWPROT and ARPROT are not used.

Decomposition:
- Shared package axi_lite_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Localparam ADDR_LSB=2.
  - Function wstrb_merge(old, new, strb) returning the byte-merged word.
- No sub-module; the block is a single flat module.

Test Plan:
- Write at addr 0x08, data 0xDEADBEEF, WSTRB 0xF, AW and W in the same cycle → BVALID one edge later with BRESP 00. reg_out[95:64]=0xDEADBEEF; reg_wr_pulse=8'b0000_0100 for 1 cycle. A read of 0x08 returns RDATA 0xDEADBEEF, RRESP 00, with RVALID one edge after the AR handshake.
- Reg2=0xDEADBEEF, then write 0x12345678 with WSTRB 0x3 → reading 0x08 returns 0xDEAD5678.
- W presented 3 cycles before AW at addr 0x04, data 0xA5A5A5A5 → WREADY low after the W handshake. Exactly one commit occurs, BRESP 00, reg1=0xA5A5A5A5.
- NUM_REGS=6, write 0x18 with data 0xFFFFFFFF → BRESP 10, all registers unchanged, no pulse. Read 0x1C → RDATA 0, RRESP 10.
- BREADY held low for 5 cycles after a write → BVALID stays high and BRESP stable; AWREADY and WREADY stay low. A second write is not accepted until the edge where BREADY=1.
- Assert S_AXI_ARESET for 1 cycle while BVALID=1 and RVALID=1 → both are 0 after that edge and every reg_out word is 0. A subsequent write at 0x00 completes normally.
